spram_word_ctrl: RTL

//  Upstream controller for one SB_SPRAM256KA (16K x 16) acting as RV32I data memory.

---
 rtl/spram_ctrl_pkg.sv | 27 ++
 rtl/spram_load_align.sv | 27 ++
 rtl/spram_word_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types and constants for the SPRAM word controller.
package spram_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        CAP,
        RESP
    } ctrl_state_t;

    // One MASKWREN bit per nibble of the 16-bit SPRAM word
    localparam logic [3:0] MASK_LO  = 4'b0011;
    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_ALL = 4'b1111;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
        return ((size == 2'b01) && low[0]) || ((size == 2'b10) && (low != 2'b00));
    endfunction

endpackage

// File: rtl/spram_load_align.sv
// Load data alignment: picks the byte/half/word out of the captured halfwords
// and sign- or zero-extends it to 32 bits.
module spram_load_align
    import spram_ctrl_pkg::*;
(
    input  logic [15:0] hw_lo,
    input  logic [15:0] hw_hi,
    input  mem_size_t   size,
    input  logic        byte_sel,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0] byte_val;

    assign byte_val = byte_sel ? hw_lo[15:8] : hw_lo[7:0];

    always_comb begin
        result = {hw_hi, hw_lo};
        case (size)
            SZ_B:    result = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
            SZ_H:    result = {{16{hw_lo[15] & ~is_unsigned}}, hw_lo};
            default: result = {hw_hi, hw_lo};
        endcase
    end

endmodule

// File: rtl/spram_word_ctrl.sv
// RV32I data-memory front end for one 16K x 16 SPRAM: splits 32-bit loads and
// stores into one or two halfword accesses and returns a single response pulse.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first SPRAM access (low halfword, or the only one)
// ACC1  | second SPRAM access of a word (high halfword); low read data captured
// CAP   | last read data on DATAOUT, load result registered on exit
// RESP  | rsp_valid pulse
module spram_word_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int ADDR_W          = 15,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [13:0]       spram_addr,
    output logic [15:0]       spram_datain,
    output logic [3:0]        spram_maskwren,
    output logic              spram_wren,
    output logic              spram_cs,
    input  logic [15:0]       spram_dataout,
    output logic              spram_standby,
    output logic              spram_sleep,
    output logic              spram_poweroff
);

    ctrl_state_t       state, state_nxt;
    logic              we_q;
    mem_size_t         size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q;
    logic              req_bad;
    logic [ADDR_W-1:0] addr_fixed;
    logic [13:0]       hw_addr;
    logic [15:0]       align_lo;
    logic [31:0]       load_result;

    assign req_bad = (req_size == 2'b11) ||
                     (ERR_ON_MISALIGN && is_misaligned(req_size, req_addr[1:0]));

    // With error reporting disabled, misaligned accesses are rounded down
    always_comb begin
        addr_fixed = req_addr;
        if (!ERR_ON_MISALIGN) begin
            if (req_size == 2'b01)
                addr_fixed[0] = 1'b0;
            else if (req_size == 2'b10)
                addr_fixed[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_bad ? RESP : ACC0;
            ACC0: begin
                if (size_q == SZ_W)
                    state_nxt = ACC1;
                else
                    state_nxt = we_q ? RESP : CAP;
            end
            ACC1:    state_nxt = we_q ? RESP : CAP;
            CAP:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= mem_size_t'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= addr_fixed;
                wdata_q <= req_wdata;
            end
            // DATAOUT is undefined during writes, so only loads capture it
            if (state == ACC1 && !we_q)
                lo_q <= spram_dataout;
            if (state_nxt == RESP) begin
                rsp_err   <= (state == IDLE);
                rsp_rdata <= (state == CAP) ? load_result : 32'h0;
            end
        end
    end

    assign align_lo = (size_q == SZ_W) ? lo_q : spram_dataout;

    spram_load_align u_align (
        .hw_lo       (align_lo),
        .hw_hi       (spram_dataout),
        .size        (size_q),
        .byte_sel    (addr_q[0]),
        .is_unsigned (uns_q),
        .result      (load_result)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign hw_addr   = 14'(addr_q[ADDR_W-1:1]);
    assign spram_cs  = (state == ACC0) || (state == ACC1);
    assign spram_wren = spram_cs && we_q;

    always_comb begin
        spram_addr     = hw_addr;
        spram_datain   = wdata_q[15:0];
        spram_maskwren = 4'b0000;
        if (size_q == SZ_W) begin
            spram_addr = {hw_addr[13:1], state == ACC1};
            if (state == ACC1)
                spram_datain = wdata_q[31:16];
        end else if (size_q == SZ_B) begin
            spram_datain = {2{wdata_q[7:0]}};
        end
        if (spram_wren) begin
            if (size_q == SZ_B)
                spram_maskwren = addr_q[0] ? MASK_HI : MASK_LO;
            else
                spram_maskwren = MASK_ALL;
        end
    end

    assign spram_standby  = 1'b0;
    assign spram_sleep    = 1'b0;
    assign spram_poweroff = 1'b1;

endmodule
